key_conditioner: RTL
====================

// Module: key_conditioner
// PURPOSE
//  Conditions the raw DE-board push-buttons (scramble, move, undo) before they reach the cube FSM.
//  Each channel is handled the same way: a 2-FF synchroniser, then a counter debouncer, then edge detection.
//  Outputs per channel: debounced level, 1-cycle press/release pulses, optional auto-repeat pulses.
//  Replaces the ad-hoc edge FFs in the top level; the FSM consumes press_pulse/repeat_pulse directly.
// PARAMETERS
//  N_KEYS          3        number of independent channels
//  ACTIVE_LOW      1        1: raw input low = pressed (KEY[]); 0: high = pressed
//  DEBOUNCE_CYCLES 500000   consecutive differing cycles required to accept a change (10 ms @ 50 MHz); >=1
//  REPEAT_EN       0        1: enable auto-repeat while held
//  REPEAT_DELAY    25000000 cycles from press_pulse to first repeat_pulse; >=1
//  REPEAT_PERIOD   5000000  cycles between subsequent repeat_pulses; >=1
// PORTS
//  clk            in   1       system clock (CLOCK_50)
//  rst            in   1       synchronous reset, active-high
//  key_raw        in   N_KEYS  asynchronous button inputs
//  key_level      out  N_KEYS  debounced pressed state (1 = pressed)
//  press_pulse    out  N_KEYS  1-cycle pulse on accepted press
//  release_pulse  out  N_KEYS  1-cycle pulse on accepted release
//  repeat_pulse   out  N_KEYS  1-cycle auto-repeat pulse (0 when REPEAT_EN=0)
//  any_press      out  1       OR of press_pulse
// BEHAVIOUR
//  - Polarity: p_raw = ACTIVE_LOW ? ~key_raw : key_raw. sync1 <= p_raw; sync2 <= sync1.
//  - Reset (rst=1 at an edge): sync1, sync2, key_level, all counters, all pulse outputs <= 0.
//    All outputs are registered. No output is asserted in the cycle after reset.
//  - Debounce, per channel: if sync2 != key_level, cnt <= cnt+1; otherwise cnt <= 0.
//    When sync2 != key_level and cnt == DEBOUNCE_CYCLES-1: key_level toggles, cnt <= 0.
//    Any mismatch gap (a bounce) restarts the count from 0.
//  - Pulses: press_pulse is registered high in exactly the cycle key_level goes 0->1.
//    release_pulse is the same for 1->0. Never both high on one channel.
//  - Latency: call the edge that first samples the new raw level edge 0.
//    key_level and press_pulse (or release_pulse) update on edge DEBOUNCE_CYCLES+1.
//  - Counter width is $clog2(DEBOUNCE_CYCLES+1). cnt never wraps; it is bounded by the rule above.
//  - Repeat FSM, per channel: IDLE -> (press) DELAY -> (REPEAT_DELAY cycles) RPT -> every REPEAT_PERIOD cycles.
//    IDLE->DELAY on press_pulse. DELAY counts REPEAT_DELAY cycles, then emits repeat_pulse and enters RPT.
//    RPT emits repeat_pulse every REPEAT_PERIOD cycles.
//    Any state -> IDLE in the same cycle key_level falls; no repeat_pulse is emitted in that cycle.
//    repeat_pulse and press_pulse never coincide. With REPEAT_EN=0 the FSM is absent and repeat_pulse=0.
//  - Channels are fully independent: simultaneous presses yield simultaneous pulses.
//  - A key held through reset: level is 0 after reset, so a press_pulse follows DEBOUNCE_CYCLES+1
//    edges after rst falls.
//  - rst asserted mid-debounce or mid-repeat aborts everything. No pulse is emitted for the aborted event.
// TESTING  (bench params: DEBOUNCE_CYCLES=4, REPEAT_EN=1, REPEAT_DELAY=10, REPEAT_PERIOD=3, ACTIVE_LOW=1)
//  1. Clean press: key_raw[0] 1->0 before edge 0, then held.
//     -> press_pulse[0]=1 only after edge 5; key_level[0]=1 from edge 5; other channels 0.
//  2. Bounce: key_raw[1] low 3 cycles, high 1 cycle, then low steady.
//     -> no pulse during the bounce; press_pulse[1] exactly once, 5 edges after the final low sample.
//  3. Release: hold key 0, then raise it.
//     -> release_pulse[0] 5 edges after the rising sample; key_level[0]=0; no repeat_pulse after that.
//  4. Auto-repeat: hold key 2 for 30 cycles past press_pulse.
//     -> repeat_pulse[2] at +10, +13, +16, ... +28; never in the press cycle.
//  5. Simultaneous: all three keys fall on the same edge.
//     -> press_pulse=3'b111 in one cycle; any_press=1 for exactly that cycle.
//  6. Reset mid-debounce: rst high 1 cycle at edge 2 of a press, key still held.
//     -> no pulse before reset; outputs 0 after reset; press_pulse at edge 5 after rst deasserts.

Source files
------------

// File: rtl/key_conditioner_if.sv
// Push-button conditioner bus: raw key inputs toward the conditioner,
// debounced level and event pulses back toward the consumer.
interface key_conditioner_if #(
  parameter int unsigned N_KEYS = 3
);
  logic [N_KEYS-1:0] key_raw;
  logic [N_KEYS-1:0] key_level;
  logic [N_KEYS-1:0] press_pulse;
  logic [N_KEYS-1:0] release_pulse;
  logic [N_KEYS-1:0] repeat_pulse;
  logic              any_press;

  modport master (
    output key_raw,
    input  key_level, press_pulse, release_pulse, repeat_pulse, any_press
  );

  modport slave (
    input  key_raw,
    output key_level, press_pulse, release_pulse, repeat_pulse, any_press
  );
endinterface

// File: rtl/key_conditioner.sv
// Per-channel push-button conditioning: 2-FF synchroniser, counter debouncer,
// registered press/release pulses and an optional auto-repeat FSM.
module key_conditioner #(
  parameter int unsigned N_KEYS          = 3,
  parameter int unsigned ACTIVE_LOW      = 1,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned REPEAT_EN       = 0,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 5000000
) (
  input  logic               clk,
  input  logic               rst,
  key_conditioner_if.slave   kif
);
  localparam int unsigned CW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RW   = $clog2(RMAX + 1);
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] RD_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RP_LAST = RW'(REPEAT_PERIOD - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DELAY = 2'd1;
  localparam logic [1:0] ST_RPT   = 2'd2;

  logic [N_KEYS-1:0] p_raw;
  logic [N_KEYS-1:0] sync1_q, sync2_q;
  logic [N_KEYS-1:0] level_q, level_d;
  logic [N_KEYS-1:0] press_q, press_d;
  logic [N_KEYS-1:0] release_q, release_d;
  logic [N_KEYS-1:0] repeat_q, repeat_d;
  logic [N_KEYS-1:0] accept;
  logic              any_q;

  assign p_raw = (ACTIVE_LOW != 0) ? ~kif.key_raw : kif.key_raw;

  for (genvar k = 0; k < N_KEYS; k++) begin : g_ch
    logic [CW-1:0] cnt_q, cnt_d;

    // Any cycle without a mismatch (a bounce) drops the count back to zero.
    assign accept[k] = (sync2_q[k] != level_q[k]) && (cnt_q == DB_LAST);
    assign cnt_d     = ((sync2_q[k] != level_q[k]) && !accept[k]) ? cnt_q + 1'b1 : '0;

    always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
    end

    if (REPEAT_EN != 0) begin : g_rpt
      logic [1:0]    st_q, st_d;
      logic [RW-1:0] rc_q, rc_d;
      logic          rep;

      // A falling level forces IDLE and masks any repeat due on that same edge.
      always_comb begin
        st_d = st_q;
        rc_d = rc_q;
        rep  = 1'b0;
        if (release_d[k]) begin
          st_d = ST_IDLE;
          rc_d = '0;
        end else begin
          case (st_q)
            ST_IDLE: begin
              if (press_d[k]) begin
                st_d = ST_DELAY;
                rc_d = '0;
              end
            end
            ST_DELAY: begin
              if (rc_q == RD_LAST) begin
                rep  = 1'b1;
                st_d = ST_RPT;
                rc_d = '0;
              end else begin
                rc_d = rc_q + 1'b1;
              end
            end
            ST_RPT: begin
              if (rc_q == RP_LAST) begin
                rep  = 1'b1;
                rc_d = '0;
              end else begin
                rc_d = rc_q + 1'b1;
              end
            end
            default: begin
              st_d = ST_IDLE;
              rc_d = '0;
            end
          endcase
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          st_q <= ST_IDLE;
          rc_q <= '0;
        end else begin
          st_q <= st_d;
          rc_q <= rc_d;
        end
      end

      assign repeat_d[k] = rep;
    end else begin : g_norpt
      assign repeat_d[k] = 1'b0;
    end
  end

  assign level_d   = level_q ^ accept;
  assign press_d   = accept & ~level_q;
  assign release_d = accept & level_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      repeat_q  <= '0;
      any_q     <= 1'b0;
    end else begin
      sync1_q   <= p_raw;
      sync2_q   <= sync1_q;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      repeat_q  <= repeat_d;
      any_q     <= |press_d;
    end
  end

  assign kif.key_level     = level_q;
  assign kif.press_pulse   = press_q;
  assign kif.release_pulse = release_q;
  assign kif.repeat_pulse  = repeat_q;
  assign kif.any_press     = any_q;
endmodule
